// File: rtl/swervolf_perf_pkg.sv
// Shared definitions for the SweRVolf branch statistics block: defaults,
// read-port address map and the per-cycle lane popcount.
package swervolf_perf_pkg;

    localparam int unsigned CNT_W_DEFAULT = 32;
    // Widest lane vector the popcount helper handles; 2-bit increments cover up to 3 lanes.
    localparam int unsigned MAX_LANES     = 3;

    localparam logic [1:0] RD_BR   = 2'd0;
    localparam logic [1:0] RD_TKN  = 2'd1;
    localparam logic [1:0] RD_MIS  = 2'd2;
    localparam logic [1:0] RD_STAT = 2'd3;

    function automatic logic [1:0] popcount_lanes(input logic [MAX_LANES-1:0] bits);
        logic [1:0] n;
        n = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            n = n + {1'b0, bits[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter: adds 0..3 per enabled cycle, sticks at all-ones
// instead of wrapping, and flags when it gets there.
module perf_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [1:0]   i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_sat
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         sat_q, sat_d;
    logic [W:0]   sum;

    always_comb begin
        // One extra bit so the carry out marks overflow.
        sum   = {1'b0, cnt_q} + {{(W-1){1'b0}}, i_inc};
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (i_clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (i_en) begin
            cnt_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
            if (&cnt_d) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign o_cnt = cnt_q;
    assign o_sat = sat_q;

endmodule

// File: rtl/swervolf_branch_stats.sv
// Retired-branch statistics for the SweRVolf core: live saturating counters,
// periodic snapshots for the seven-segment display and a registered read port.
module swervolf_branch_stats
    import swervolf_perf_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned SNAP_CYCLES = 100000000,
    parameter int unsigned LANES       = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic [LANES-1:0] i_br_valid,
    input  logic [LANES-1:0] i_br_taken,
    input  logic [LANES-1:0] i_br_mispred,
    input  logic [1:0]       i_rd_addr,
    output logic [CNT_W-1:0] o_rd_data,
    output logic [CNT_W-1:0] o_br_count,
    output logic [CNT_W-1:0] o_taken_count,
    output logic             o_snap_valid,
    output logic             o_sat
);

    localparam int unsigned TW = (SNAP_CYCLES > 1) ? $clog2(SNAP_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(SNAP_CYCLES - 1);

    logic [MAX_LANES-1:0] valid_ext, taken_ext, mis_ext;
    logic [1:0]           inc_br, inc_tkn, inc_mis;
    logic [CNT_W-1:0]     cnt_br, cnt_tkn, cnt_mis;
    logic                 sat_br, sat_tkn, sat_mis;

    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] snap_br_q, snap_br_d;
    logic [CNT_W-1:0] snap_tkn_q, snap_tkn_d;
    logic             snap_valid_q, snap_valid_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;

    // Taken/mispredict bits only count on lanes that actually retired a branch.
    always_comb begin
        valid_ext = '0;
        taken_ext = '0;
        mis_ext   = '0;
        valid_ext[LANES-1:0] = i_br_valid;
        taken_ext[LANES-1:0] = i_br_valid & i_br_taken;
        mis_ext[LANES-1:0]   = i_br_valid & i_br_mispred;
        inc_br  = popcount_lanes(valid_ext);
        inc_tkn = popcount_lanes(taken_ext);
        inc_mis = popcount_lanes(mis_ext);
    end

    perf_sat_counter #(.W(CNT_W)) u_cnt_br (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clear),
        .i_en  (i_en),
        .i_inc (inc_br),
        .o_cnt (cnt_br),
        .o_sat (sat_br)
    );

    perf_sat_counter #(.W(CNT_W)) u_cnt_tkn (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clear),
        .i_en  (i_en),
        .i_inc (inc_tkn),
        .o_cnt (cnt_tkn),
        .o_sat (sat_tkn)
    );

    perf_sat_counter #(.W(CNT_W)) u_cnt_mis (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clear),
        .i_en  (i_en),
        .i_inc (inc_mis),
        .o_cnt (cnt_mis),
        .o_sat (sat_mis)
    );

    assign o_sat = sat_br | sat_tkn | sat_mis;

    // Snapshot takes the live values from the start of the terminal cycle; clear overrides it.
    always_comb begin
        timer_d      = timer_q + 1'b1;
        snap_br_d    = snap_br_q;
        snap_tkn_d   = snap_tkn_q;
        snap_valid_d = 1'b0;
        if (i_clear) begin
            timer_d    = '0;
            snap_br_d  = '0;
            snap_tkn_d = '0;
        end else if (timer_q == TIMER_LAST) begin
            timer_d      = '0;
            snap_br_d    = cnt_br;
            snap_tkn_d   = cnt_tkn;
            snap_valid_d = 1'b1;
        end
    end

    always_comb begin
        rd_data_d = '0;
        unique case (i_rd_addr)
            RD_BR:   rd_data_d = cnt_br;
            RD_TKN:  rd_data_d = cnt_tkn;
            RD_MIS:  rd_data_d = cnt_mis;
            RD_STAT: rd_data_d = {{(CNT_W-2){1'b0}}, i_en, o_sat};
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timer_q      <= '0;
            snap_br_q    <= '0;
            snap_tkn_q   <= '0;
            snap_valid_q <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            timer_q      <= timer_d;
            snap_br_q    <= snap_br_d;
            snap_tkn_q   <= snap_tkn_d;
            snap_valid_q <= snap_valid_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign o_rd_data     = rd_data_q;
    assign o_br_count    = snap_br_q;
    assign o_taken_count = snap_tkn_q;
    assign o_snap_valid  = snap_valid_q;

endmodule

// File: tb/tb_swervolf_branch_stats.sv
// Bench for swervolf_branch_stats: a 32-bit and a 4-bit instance share stimulus
// and are compared every cycle against an arithmetic model, plus directed sequences.
module tb_swervolf_branch_stats;

    localparam int SNAP = 8;

    logic       clk = 1'b0;
    logic       rst, clr, en;
    logic [1:0] bv, bt, bm, addr;

    logic [31:0] rd_a, br_a, tk_a;
    logic        sv_a, sat_a;
    logic [3:0]  rd_b, br_b, tk_b;
    logic        sv_b, sat_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    swervolf_branch_stats #(.CNT_W(32), .SNAP_CYCLES(SNAP), .LANES(2)) dut_a (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_clear       (clr),
        .i_br_valid    (bv),
        .i_br_taken    (bt),
        .i_br_mispred  (bm),
        .i_rd_addr     (addr),
        .o_rd_data     (rd_a),
        .o_br_count    (br_a),
        .o_taken_count (tk_a),
        .o_snap_valid  (sv_a),
        .o_sat         (sat_a)
    );

    swervolf_branch_stats #(.CNT_W(4), .SNAP_CYCLES(SNAP), .LANES(2)) dut_b (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_clear       (clr),
        .i_br_valid    (bv),
        .i_br_taken    (bt),
        .i_br_mispred  (bm),
        .i_rd_addr     (addr),
        .o_rd_data     (rd_b),
        .o_br_count    (br_b),
        .o_taken_count (tk_b),
        .o_snap_valid  (sv_b),
        .o_sat         (sat_b)
    );

    // Reference model, index 0 = 32-bit instance, 1 = 4-bit instance.
    longint maxv [2];
    longint live [2][3];
    longint snap_br [2];
    longint snap_tk [2];
    longint rd_exp [2];
    longint snapv_m [2];
    longint sat_m [2];
    int     timer_m;

    function automatic int pop2(input logic [1:0] v);
        return int'(v[0]) + int'(v[1]);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) live[d][k] = 0;
            snap_br[d] = 0;
            snap_tk[d] = 0;
            rd_exp[d]  = 0;
            snapv_m[d] = 0;
            sat_m[d]   = 0;
        end
        timer_m = 0;
    endtask

    task automatic model_step();
        int inc [3];
        inc[0] = pop2(bv);
        inc[1] = pop2(bv & bt);
        inc[2] = pop2(bv & bm);
        for (int d = 0; d < 2; d++) begin
            if (addr == 2'd3) rd_exp[d] = (en ? 2 : 0) + sat_m[d];
            else              rd_exp[d] = live[d][int'(addr)];
        end
        if (rst) begin
            model_reset();
        end else if (clr) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 3; k++) live[d][k] = 0;
                snap_br[d] = 0;
                snap_tk[d] = 0;
                snapv_m[d] = 0;
                sat_m[d]   = 0;
            end
            timer_m = 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (timer_m == SNAP - 1) begin
                    snap_br[d] = live[d][0];
                    snap_tk[d] = live[d][1];
                    snapv_m[d] = 1;
                end else begin
                    snapv_m[d] = 0;
                end
                if (en) begin
                    for (int k = 0; k < 3; k++) begin
                        live[d][k] = live[d][k] + inc[k];
                        if (live[d][k] >= maxv[d]) begin
                            live[d][k] = maxv[d];
                            sat_m[d]   = 1;
                        end
                    end
                end
            end
            timer_m = (timer_m == SNAP - 1) ? 0 : timer_m + 1;
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a_rd_data", longint'(rd_a), rd_exp[0]);
        chk("a_br_snap", longint'(br_a), snap_br[0]);
        chk("a_tk_snap", longint'(tk_a), snap_tk[0]);
        chk("a_snap_valid", longint'(sv_a), snapv_m[0]);
        chk("a_sat", longint'(sat_a), sat_m[0]);
        chk("b_rd_data", longint'(rd_b), rd_exp[1]);
        chk("b_br_snap", longint'(br_b), snap_br[1]);
        chk("b_tk_snap", longint'(tk_b), snap_tk[1]);
        chk("b_snap_valid", longint'(sv_b), snapv_m[1]);
        chk("b_sat", longint'(sat_b), sat_m[1]);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic r, input logic c, input logic e, input logic [1:0] v,
                         input logic [1:0] t, input logic [1:0] m, input logic [1:0] a);
        rst = r; clr = c; en = e; bv = v; bt = t; bm = m; addr = a;
    endtask

    typedef struct {
        logic [1:0] v, t, m, a;
        logic       e;
        longint     exp_rd;
    } vec_t;

    vec_t tbl [13];
    int   first_i, second_i;
    longint first_br, second_br;

    initial begin
        maxv[0] = 64'hFFFF_FFFF;
        maxv[1] = 64'hF;
        model_reset();

        // Each row: inputs for one cycle; exp_rd is the selected live value before that cycle.
        tbl[0]  = '{v: 2'b11, t: 2'b01, m: 2'b00, a: 2'd0, e: 1'b1, exp_rd: 0};
        tbl[1]  = '{v: 2'b11, t: 2'b01, m: 2'b00, a: 2'd0, e: 1'b1, exp_rd: 2};
        tbl[2]  = '{v: 2'b11, t: 2'b01, m: 2'b00, a: 2'd1, e: 1'b1, exp_rd: 2};
        tbl[3]  = '{v: 2'b11, t: 2'b01, m: 2'b00, a: 2'd0, e: 1'b1, exp_rd: 6};
        tbl[4]  = '{v: 2'b11, t: 2'b01, m: 2'b00, a: 2'd1, e: 1'b1, exp_rd: 4};
        tbl[5]  = '{v: 2'b00, t: 2'b11, m: 2'b11, a: 2'd0, e: 1'b1, exp_rd: 10};
        tbl[6]  = '{v: 2'b00, t: 2'b00, m: 2'b11, a: 2'd1, e: 1'b1, exp_rd: 5};
        tbl[7]  = '{v: 2'b10, t: 2'b00, m: 2'b11, a: 2'd2, e: 1'b1, exp_rd: 0};
        tbl[8]  = '{v: 2'b10, t: 2'b00, m: 2'b11, a: 2'd2, e: 1'b1, exp_rd: 1};
        tbl[9]  = '{v: 2'b10, t: 2'b00, m: 2'b11, a: 2'd1, e: 1'b1, exp_rd: 5};
        tbl[10] = '{v: 2'b00, t: 2'b00, m: 2'b00, a: 2'd2, e: 1'b1, exp_rd: 3};
        tbl[11] = '{v: 2'b00, t: 2'b00, m: 2'b00, a: 2'd0, e: 1'b1, exp_rd: 13};
        tbl[12] = '{v: 2'b00, t: 2'b00, m: 2'b00, a: 2'd3, e: 1'b1, exp_rd: 2};

        drive(1, 0, 1, 2'b00, 2'b00, 2'b00, 2'd0);
        cycle();
        cycle();
        chk("reset_rd", longint'(rd_a), 0);
        chk("reset_sat", longint'(sat_a), 0);

        // Counting, qualification and read latency.
        for (int i = 0; i < 13; i++) begin
            drive(0, 0, tbl[i].e, tbl[i].v, tbl[i].t, tbl[i].m, tbl[i].a);
            cycle();
            chk($sformatf("tbl_rd[%0d]", i), longint'(rd_a), tbl[i].exp_rd);
        end

        // Snapshot cadence from reset with one branch per cycle.
        drive(1, 0, 1, 2'b00, 2'b00, 2'b00, 2'd0);
        cycle();
        drive(0, 0, 1, 2'b01, 2'b00, 2'b00, 2'd0);
        first_i = -1; second_i = -1; first_br = -1; second_br = -1;
        for (int i = 0; i < 40 && second_i < 0; i++) begin
            cycle();
            if (sv_a) begin
                if (first_i < 0) begin first_i = i; first_br = longint'(br_a); end
                else begin second_i = i; second_br = longint'(br_a); end
            end
        end
        chk("snap_first_cycle", first_i, 7);
        chk("snap_first_br", first_br, 7);
        chk("snap_period", second_i - first_i, 8);
        chk("snap_second_br", second_br, 15);

        // 4-bit instance saturates, status read, then clear.
        drive(1, 0, 1, 2'b00, 2'b00, 2'b00, 2'd0);
        cycle();
        drive(0, 0, 1, 2'b11, 2'b00, 2'b00, 2'd0);
        for (int i = 0; i < 8; i++) cycle();
        drive(0, 0, 1, 2'b00, 2'b00, 2'b00, 2'd0);
        cycle();
        chk("sat4_br_read", longint'(rd_b), 15);
        chk("sat4_flag", longint'(sat_b), 1);
        drive(0, 0, 1, 2'b00, 2'b00, 2'b00, 2'd3);
        cycle();
        chk("sat4_status", longint'(rd_b), 3);
        drive(0, 1, 1, 2'b11, 2'b00, 2'b00, 2'd0);
        cycle();
        chk("clear_sat", longint'(sat_b), 0);
        chk("clear_snap_b", longint'(br_b), 0);
        drive(0, 0, 1, 2'b00, 2'b00, 2'b00, 2'd0);
        cycle();
        chk("clear_live_b", longint'(rd_b), 0);

        // Clear landing on the terminal-count cycle.
        drive(0, 0, 1, 2'b01, 2'b01, 2'b00, 2'd0);
        for (int i = 0; i < 10 && timer_m != SNAP - 1; i++) cycle();
        chk("reach_terminal", timer_m, SNAP - 1);
        drive(0, 1, 1, 2'b11, 2'b11, 2'b11, 2'd0);
        cycle();
        chk("clr_term_snapv", longint'(sv_a), 0);
        chk("clr_term_snap", longint'(br_a), 0);
        drive(0, 0, 1, 2'b01, 2'b00, 2'b00, 2'd0);
        first_i = -1; first_br = -1;
        for (int i = 0; i < 20 && first_i < 0; i++) begin
            cycle();
            if (sv_a) begin first_i = i; first_br = longint'(br_a); end
        end
        chk("clr_term_restart", first_i, 7);
        chk("clr_term_br", first_br, 7);

        // Enable freeze with snapshots still running, then reset mid-interval.
        drive(1, 0, 1, 2'b00, 2'b00, 2'b00, 2'd0);
        cycle();
        drive(0, 0, 1, 2'b11, 2'b00, 2'b00, 2'd0);
        for (int i = 0; i < 3; i++) cycle();
        drive(0, 0, 0, 2'b11, 2'b00, 2'b00, 2'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("freeze_rd", longint'(rd_a), 6);
        end
        drive(0, 0, 1, 2'b11, 2'b00, 2'b00, 2'd0);
        cycle();
        cycle();
        chk("freeze_live", longint'(rd_a), 8);
        chk("freeze_snapv", longint'(sv_a), 1);
        chk("freeze_snap", longint'(br_a), 8);
        for (int i = 0; i < 3; i++) cycle();
        drive(1, 0, 1, 2'b11, 2'b11, 2'b11, 2'd0);
        cycle();
        chk("midrst_rd", longint'(rd_a), 0);
        chk("midrst_br", longint'(br_a), 0);
        chk("midrst_tk", longint'(tk_a), 0);
        chk("midrst_snapv", longint'(sv_a), 0);
        chk("midrst_sat", longint'(sat_a), 0);
        drive(0, 0, 1, 2'b00, 2'b00, 2'b00, 2'd0);
        cycle();
        chk("midrst_no_snap", longint'(sv_a), 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(63) == 0), ($urandom_range(31) == 0),
                  ($urandom_range(7) != 0), 2'($urandom), 2'($urandom), 2'($urandom),
                  2'($urandom));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
